// File: rtl/inst_encoder_pkg.sv
// Shared immediate-format encodings, error codes and RV32I opcodes.
// Used by both the encoder and the decode-side immediate generator.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    SEL_I     = 3'd0,
    SEL_S     = 3'd1,
    SEL_B     = 3'd2,
    SEL_J     = 3'd3,
    SEL_LUI   = 3'd4,
    SEL_AUIPC = 3'd5
  } imm_sel_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_SEL   = 2'b11;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Bits above the field's sign bit; all must match it.
  localparam logic [31:0] HI_I = 32'hFFFF_F800;
  localparam logic [31:0] HI_B = 32'hFFFF_F000;
  localparam logic [31:0] HI_J = 32'hFFF0_0000;

  function automatic logic sext_ok(
    input logic [31:0] imm,
    input logic [31:0] hi
  );
    return ((imm & hi) == hi) || ((imm & hi) == '0);
  endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational packer: immediate + fields -> RV32I word,
// with range/alignment/select checking.
module imm_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  output logic [31:0] inst,
  output logic [1:0]  err_code
);

  logic is_i, is_s, is_b, is_j, is_u;

  assign is_i = (sel == SEL_I);
  assign is_s = (sel == SEL_S);
  assign is_b = (sel == SEL_B);
  assign is_j = (sel == SEL_J);
  assign is_u = (sel == SEL_LUI) || (sel == SEL_AUIPC);

  always_comb begin
    inst     = '0;
    err_code = ERR_NONE;
    unique case (1'b1)
      is_i: begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        if (!sext_ok(imm, HI_I)) err_code = ERR_RANGE;
      end
      is_s: begin
        inst = {imm[11:5], rs2, rs1, funct3,
                imm[4:0], opcode};
        if (!sext_ok(imm, HI_I)) err_code = ERR_RANGE;
      end
      is_b: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3,
                imm[4:1], imm[11], opcode};
        if (imm[0])                  err_code = ERR_ALIGN;
        else if (!sext_ok(imm, HI_B)) err_code = ERR_RANGE;
      end
      is_j: begin
        inst = {imm[20], imm[10:1], imm[11],
                imm[19:12], rd, opcode};
        if (imm[0])                  err_code = ERR_ALIGN;
        else if (!sext_ok(imm, HI_J)) err_code = ERR_RANGE;
      end
      is_u: begin
        inst = {imm[31:12], rd, opcode};
        if (|imm[11:0]) err_code = ERR_ALIGN;
      end
      default: err_code = ERR_SEL;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs immediates into RV32I words and streams
// them with sequential imem write addresses over valid/ready.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2048
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_imm_sel,
  input  logic [31:0] i_imm,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_addr,
  input  logic        i_clear,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  localparam logic [31:0] LAST_ADDR =
    BASE_ADDR + 32'(4 * (DEPTH - 1));

  logic [31:0] p_inst;
  logic [1:0]  p_err;
  logic        acc, hs, bad;

  imm_pack u_pack (
    .sel      (i_imm_sel),
    .imm      (i_imm),
    .opcode   (i_opcode),
    .rd       (i_rd),
    .rs1      (i_rs1),
    .rs2      (i_rs2),
    .funct3   (i_funct3),
    .inst     (p_inst),
    .err_code (p_err)
  );

  assign o_ready = !o_valid || i_ready;
  assign acc     = i_valid && o_ready;
  assign hs      = o_valid && i_ready;
  assign bad     = (p_err != ERR_NONE);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_valid    <= 1'b0;
      o_inst     <= '0;
      o_addr     <= BASE_ADDR;
      o_err      <= 1'b0;
      o_err_code <= ERR_NONE;
    end else begin
      o_err <= acc && bad;
      if (acc && bad) o_err_code <= p_err;

      if (acc && !bad) begin
        o_inst  <= p_inst;
        o_valid <= 1'b1;
      end else if (hs) begin
        o_valid <= 1'b0;
      end

      // Clear beats the handshake step; a held word pairs with BASE.
      if (i_clear)
        o_addr <= BASE_ADDR;
      else if (hs)
        o_addr <= (o_addr == LAST_ADDR) ? BASE_ADDR
                                        : o_addr + 32'd4;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: reference legality model,
// decode-side round-trip check, address and error-pulse tracking.
module tb_inst_encoder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 4;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        gold_en;
    logic [31:0] gold;
  } req_t;

  logic        clk;
  logic        i_reset, i_valid, i_ready, i_clear;
  logic [2:0]  i_imm_sel;
  logic [31:0] i_imm;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [2:0]  i_funct3;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_inst, o_addr;
  logic [1:0]  o_err_code;

  inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_imm_sel  (i_imm_sel),
    .i_imm      (i_imm),
    .i_opcode   (i_opcode),
    .i_rd       (i_rd),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .i_funct3   (i_funct3),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_inst     (o_inst),
    .o_addr     (o_addr),
    .i_clear    (i_clear),
    .o_err      (o_err),
    .o_err_code (o_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  req_t drv_req;
  req_t exp_q[$];
  bit   live = 0, just_rst = 0, acc_pend = 0;
  bit   merr = 0;
  int   mcode = 0;
  int   aidx = 0;
  bit   rand_mode = 0, rdy_val = 1, clr_req = 0;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Legality from the numeric range of each format.
  function automatic int ref_err(req_t r);
    int v;
    v = $signed(r.imm);
    case (r.sel)
      3'd0, 3'd1: return (v >= -2048 && v <= 2047) ? 0 : 1;
      3'd2: begin
        if (v % 2 != 0) return 2;
        return (v >= -4096 && v <= 4095) ? 0 : 1;
      end
      3'd3: begin
        if (v % 2 != 0) return 2;
        return (v >= -1048576 && v <= 1048575) ? 0 : 1;
      end
      3'd4, 3'd5: return (r.imm % 4096 != 0) ? 2 : 0;
      default: return 3;
    endcase
  endfunction

  // Decode-side immediate generator plus field extraction.
  function automatic bit dec_ok(req_t r, logic [31:0] w);
    logic [31:0] d;
    bit ok;
    ok = (w[6:0] == r.op);
    case (r.sel)
      3'd0: begin
        d  = {{20{w[31]}}, w[31:20]};
        ok &= (w[11:7] == r.rd) && (w[19:15] == r.rs1)
              && (w[14:12] == r.f3);
      end
      3'd1: begin
        d  = {{20{w[31]}}, w[31:25], w[11:7]};
        ok &= (w[24:20] == r.rs2) && (w[19:15] == r.rs1)
              && (w[14:12] == r.f3);
      end
      3'd2: begin
        d  = {{19{w[31]}}, w[31], w[7], w[30:25],
              w[11:8], 1'b0};
        ok &= (w[24:20] == r.rs2) && (w[19:15] == r.rs1)
              && (w[14:12] == r.f3);
      end
      3'd3: begin
        d  = {{11{w[31]}}, w[31], w[19:12], w[20],
              w[30:21], 1'b0};
        ok &= (w[11:7] == r.rd);
      end
      default: begin
        d  = {w[31:12], 12'h000};
        ok &= (w[11:7] == r.rd);
      end
    endcase
    return ok && (d == r.imm);
  endfunction

  // Monitor/predictor: check state after the last edge, then
  // predict the effect of the upcoming edge from current inputs.
  always @(negedge clk) begin
    bit hs, acc, mvalid;
    int code;
    mvalid = (exp_q.size() != 0);
    if (live) begin
      chk("o_valid", 32'(o_valid), 32'(mvalid));
      chk("o_ready", 32'(o_ready), 32'(!mvalid || i_ready));
      chk("o_err", 32'(o_err), 32'(merr));
      chk("o_err_code", 32'(o_err_code), 32'(mcode));
      if (just_rst) begin
        chk("reset o_inst", o_inst, 32'h0);
        chk("reset o_addr", o_addr, BASE);
      end
      if (mvalid && o_valid) begin
        chk("o_addr", o_addr, BASE + 32'(4 * aidx));
        checks++;
        if (!dec_ok(exp_q[0], o_inst)) begin
          errors++;
          $display("FAIL decode: got inst %h expected sel %0d imm %h",
                   o_inst, exp_q[0].sel, exp_q[0].imm);
        end
        if (exp_q[0].gold_en) chk("golden inst", o_inst, exp_q[0].gold);
      end
    end
    if (!i_reset) begin
      exp_q.delete();
      live = 1; just_rst = 1; acc_pend = 0;
      merr = 0; mcode = 0; aidx = 0;
    end else if (live) begin
      just_rst = 0;
      hs   = mvalid && i_ready;
      acc  = i_valid && (!mvalid || i_ready);
      code = ref_err(drv_req);
      merr = acc && (code != 0);
      if (merr) mcode = code;
      if (hs) void'(exp_q.pop_front());
      if (acc && code == 0) exp_q.push_back(drv_req);
      if (i_clear) aidx = 0;
      else if (hs) aidx = (aidx + 1) % DEPTH;
      acc_pend = acc;
    end
  end

  // Ready/clear driver, applied after the main thread's #1 updates.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      i_ready = rand_mode ? ($urandom_range(0, 3) != 0) : rdy_val;
      i_clear = rand_mode ? ($urandom_range(0, 19) == 0) : clr_req;
    end
  end

  task automatic set_req(req_t r);
    drv_req   = r;
    i_imm_sel = r.sel;
    i_imm     = r.imm;
    i_opcode  = r.op;
    i_rd      = r.rd;
    i_rs1     = r.rs1;
    i_rs2     = r.rs2;
    i_funct3  = r.f3;
  endtask

  task automatic send(req_t r);
    bit done;
    done = 0;
    set_req(r);
    i_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(posedge clk);
      #1;
      done = acc_pend;
    end
    i_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept timeout: got no accept expected accept in 100 cycles");
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic req_t mk(logic [2:0] s, logic [31:0] imm,
                              logic [6:0] op, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2,
                              logic [2:0] f3);
    req_t r;
    r.sel = s; r.imm = imm; r.op = op; r.rd = rd;
    r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3;
    r.gold_en = 1'b0; r.gold = '0;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int lo, hi, k;
    r = mk(3'($urandom_range(0, 5)), $urandom,
           7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 3'($urandom));
    if ($urandom_range(0, 9) == 0) r.sel = 3'($urandom_range(6, 7));
    case (r.sel)
      3'd0, 3'd1: begin lo = -2048;    hi = 2047;    end
      3'd2:       begin lo = -4096;    hi = 4095;    end
      3'd3:       begin lo = -1048576; hi = 1048575; end
      default:    begin lo = 0;        hi = 0;       end
    endcase
    k = $urandom_range(0, 3);
    if (k == 1 && r.sel <= 3'd3) begin
      r.imm = 32'(lo + int'($urandom_range(0, 32'(hi - lo))));
      if (r.sel >= 3'd2) r.imm[0] = 1'b0;
    end else if (k == 1) begin
      r.imm = $urandom & 32'hFFFF_F000;
    end else if (k == 2) begin
      case ($urandom_range(0, 4))
        0: r.imm = 32'(lo);
        1: r.imm = 32'(hi);
        2: r.imm = 32'(hi - 1);
        3: r.imm = 32'(lo - 2);
        default: r.imm = 32'(hi + 1);
      endcase
    end else if (k == 3) begin
      r.imm = 32'(int'($urandom_range(0, 64)) - 32);
    end
    return r;
  endfunction

  initial begin
    req_t r;
    bit drained;
    i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_clear = 1'b0;
    set_req(mk(3'd0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0));
    idle(3);
    i_reset = 1'b1;
    idle(2);

    r = mk(3'd0, 32'hFFFF_FFFF, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'd0);
    r.gold_en = 1'b1; r.gold = 32'hFFF3_0293;
    send(r);
    r = mk(3'd2, 32'hFFFF_FFFC, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0);
    r.gold_en = 1'b1; r.gold = 32'hFE20_8EE3;
    send(r);
    send(mk(3'd2, 32'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0));
    idle(2);
    send(mk(3'd0, 32'd2048, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0));
    idle(2);
    send(mk(3'd7, 32'd2048, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0));
    idle(2);
    send(mk(3'd4, 32'hABCD_E000, 7'b0110111, 5'd9, 5'd0, 5'd0, 3'd0));
    send(mk(3'd3, 32'hFFF0_0000, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0));
    idle(3);

    rdy_val = 1'b0;
    fork
      begin
        send(mk(3'd1, 32'd100, 7'b0100011, 5'd0, 5'd3, 5'd4, 3'd2));
        send(mk(3'd0, 32'd7, 7'b0010011, 5'd8, 5'd9, 5'd0, 3'd1));
        send(mk(3'd5, 32'h0001_0000, 7'b0010111, 5'd2, 5'd0, 5'd0, 3'd0));
      end
      begin
        idle(8);
        rdy_val = 1'b1;
      end
    join
    idle(3);

    for (int n = 0; n < 5; n++) send(rand_req());
    idle(2);
    send(mk(3'd0, 32'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0));
    clr_req = 1'b1;
    idle(1);
    clr_req = 1'b0;
    idle(2);

    rdy_val = 1'b0;
    send(mk(3'd0, 32'd2, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0));
    clr_req = 1'b1;
    idle(1);
    clr_req = 1'b0;
    idle(2);
    rdy_val = 1'b1;
    idle(2);

    rdy_val = 1'b0;
    send(mk(3'd0, 32'd3, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0));
    set_req(mk(3'd2, 32'd5, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0));
    i_valid = 1'b1;
    rdy_val = 1'b1;
    i_reset = 1'b0;
    idle(1);
    i_reset = 1'b1;
    i_valid = 1'b0;
    idle(3);

    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      send(rand_req());
      idle($urandom_range(0, 2));
    end
    rand_mode = 1'b0;
    rdy_val = 1'b1;
    drained = 0;
    for (int n = 0; n < 50 && !drained; n++) begin
      idle(1);
      drained = (exp_q.size() == 0);
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
